// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl: multi-cycle Moore sequencer for the 8x16 register-file datapath.
// Handshake: w is high only in WAIT; a high s in a WAIT cycle is accepted at the next
// rising edge, which latches `in` into the instruction register and leaves WAIT. While
// the sequence runs, s and `in` are ignored, so the instruction register is stable for
// the whole sequence. The instruction source must hold the word valid in the WAIT cycle
// in which it raises s.
module regfile_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [WIDTH-1:0] in,
    output logic             w,
    output logic             err,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [WIDTH-1:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;

    // Instruction fields
    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op, sh;
    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign sximm8 = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};

    // Instruction classes
    logic is_alu_grp, is_movi, is_movr, is_cmp, is_mvn, is_legal;
    assign is_alu_grp = (opcode == 3'b101);
    assign is_movi    = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr    = (opcode == 3'b110) && (op == 2'b00);
    assign is_cmp     = is_alu_grp && (op == 2'b01);
    assign is_mvn     = is_alu_grp && (op == 2'b11);
    assign is_legal   = is_alu_grp || is_movi || is_movr;

    // State and instruction registers; reset forces WAIT and clears the instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Instruction register loads only when a start is accepted in WAIT
    always_comb begin
        ir_d = ir_q;
        if ((state_q == S_WAIT) && s) begin
            ir_d = in;
        end
    end

    // Next-state and Moore outputs from state and the latched instruction
    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 2'd0;
        shift    = 2'd0;
        ALUop    = 2'd0;
        unique case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!is_legal) begin
                    err     = 1'b1;
                    state_d = S_WAIT;
                end else if (is_movi) begin
                    state_d = S_WR_IMM;
                end else if (is_movr || is_mvn) begin
                    state_d = S_GET_B;
                end else begin
                    state_d = S_GET_A;
                end
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_ALU;
            end
            S_ALU: begin
                shift = sh;
                ALUop = is_alu_grp ? op : 2'b00;
                asel  = is_movr || is_mvn;
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    loadc   = 1'b1;
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: begin
                write    = 1'b1;
                writenum = rd;
                vsel     = 2'd0;
                state_d  = S_WAIT;
            end
            S_WR_IMM: begin
                write    = 1'b1;
                writenum = rn;
                vsel     = 2'd2;
                state_d  = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: directed program plus randomized instructions checked
// against an instruction-level reference model (step list per instruction class).
module tb_regfile_seq_ctrl;

    localparam int WIDTH = 16;

    // Clock and reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, s;
    logic [WIDTH-1:0] in;
    logic             w, err, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]       readnum, writenum;
    logic [1:0]       vsel, shift, ALUop;
    logic [WIDTH-1:0] sximm8;

    regfile_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .s(s), .in(in), .w(w), .err(err),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8)
    );

    logic [20:0] got_v;
    assign got_v = {w, err, readnum, writenum, write, loada, loadb, loadc, loads,
                    asel, bsel, vsel, shift, ALUop};

    int checks = 0;
    int errors = 0;
    logic [15:0] ir_m = 16'h0000;

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: instruction kinds
    localparam int K_ILL = 0, K_MOVI = 1, K_MOVR = 2, K_ADD = 3, K_CMP = 4, K_AND = 5, K_MVN = 6;
    // Step codes
    localparam int C_WAIT = 0, C_DEC = 1, C_GA = 2, C_GB = 3, C_ALU = 4, C_WRD = 5, C_WRI = 6;

    function automatic int kind(input logic [15:0] ir);
        if (ir[15:13] == 3'b110) begin
            if (ir[12:11] == 2'b10) return K_MOVI;
            if (ir[12:11] == 2'b00) return K_MOVR;
            return K_ILL;
        end
        if (ir[15:13] == 3'b101) begin
            case (ir[12:11])
                2'b00:   return K_ADD;
                2'b01:   return K_CMP;
                2'b10:   return K_AND;
                default: return K_MVN;
            endcase
        end
        return K_ILL;
    endfunction

    function automatic int seq_len(input logic [15:0] ir);
        case (kind(ir))
            K_ILL:              return 1;
            K_MOVI:             return 2;
            K_MOVR, K_MVN, K_CMP: return 4;
            default:            return 5;
        endcase
    endfunction

    function automatic int step_code(input logic [15:0] ir, input int k);
        int kd;
        kd = kind(ir);
        if (k == 0) return C_DEC;
        if (kd == K_MOVI) return C_WRI;
        if (kd == K_MOVR || kd == K_MVN) return (k == 1) ? C_GB : (k == 2) ? C_ALU : C_WRD;
        return (k == 1) ? C_GA : (k == 2) ? C_GB : (k == 3) ? C_ALU : C_WRD;
    endfunction

    function automatic int exp_writes(input logic [15:0] ir);
        int kd;
        kd = kind(ir);
        return (kd == K_ILL || kd == K_CMP) ? 0 : 1;
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] ir);
        int v;
        v = (ir[7:0] >= 8'd128) ? int'(ir[7:0]) - 256 : int'(ir[7:0]);
        return {16'h0000, 16'(v)};
    endfunction

    function automatic logic [20:0] exp_out(input logic [15:0] ir, input int code);
        logic ew, eerr, ewr, la, lb, lc, ls, as;
        logic [2:0] rn, wn;
        logic [1:0] vs, sh, alu;
        int kd;
        kd = kind(ir);
        {ew, eerr, ewr, la, lb, lc, ls, as} = '0;
        rn = 3'd0; wn = 3'd0; vs = 2'd0; sh = 2'd0; alu = 2'd0;
        case (code)
            C_WAIT: ew = 1'b1;
            C_DEC:  eerr = (kd == K_ILL);
            C_GA:   begin rn = ir[10:8]; la = 1'b1; end
            C_GB:   begin rn = ir[2:0];  lb = 1'b1; end
            C_ALU: begin
                sh  = ir[4:3];
                alu = (kd == K_MOVR) ? 2'b00 : ir[12:11];
                as  = (kd == K_MOVR || kd == K_MVN);
                ls  = (kd == K_CMP);
                lc  = (kd != K_CMP);
            end
            C_WRD:  begin ewr = 1'b1; wn = ir[7:5]; vs = 2'd0; end
            C_WRI:  begin ewr = 1'b1; wn = ir[10:8]; vs = 2'd2; end
            default: ;
        endcase
        return {ew, eerr, rn, wn, ewr, la, lb, lc, ls, as, 1'b0, vs, sh, alu};
    endfunction

    // Driver: issue one instruction from WAIT (just after an edge) and follow it back to WAIT
    task automatic run_instr(input logic [15:0] instr, input bit hold);
        int lat, wr_cnt;
        check("wait_outs", {11'd0, got_v}, {11'd0, exp_out(ir_m, C_WAIT)});
        check("wait_sx", {16'd0, sximm8}, sx(ir_m));
        s  = 1'b1;
        in = instr;
        @(posedge clk); #1;
        ir_m   = instr;
        lat    = seq_len(instr);
        wr_cnt = 0;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("i%04h_step%0d", instr, k), {11'd0, got_v},
                  {11'd0, exp_out(ir_m, step_code(ir_m, k))});
            check($sformatf("i%04h_sx%0d", instr, k), {16'd0, sximm8}, sx(ir_m));
            if (write) wr_cnt++;
            s  = hold ? 1'b1 : 1'($urandom_range(0, 1));
            in = 16'($urandom);
        end
        s = hold;
        check($sformatf("i%04h_writes", instr), wr_cnt, exp_writes(instr));
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 9))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            6: r[15:11] = 5'b11001;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        in    = '0;
        #1;
        check("reset_outs", {11'd0, got_v}, {11'd0, exp_out(16'h0000, C_WAIT)});
        check("reset_sx", {16'd0, sximm8}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // Directed program
        run_instr(16'hD007, 1'b0);
        run_instr(16'hD1FE, 1'b0);
        run_instr(16'hA140, 1'b0);
        run_instr(16'hA801, 1'b0);
        run_instr(16'h0000, 1'b0);
        run_instr(16'hB8E3, 1'b1);
        run_instr(16'hC05A, 1'b1);

        // Idle WAIT with s low: stays in WAIT
        s = 1'b0;
        @(posedge clk); #1;
        check("idle_w", {31'd0, w}, 32'd1);

        // Asynchronous reset during ALU of ADD R2,R1,R0
        s  = 1'b1;
        in = 16'hA140;
        @(posedge clk); #1;
        s  = 1'b0;
        in = 16'hFFFF;
        ir_m = 16'hA140;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_alu", {11'd0, got_v}, {11'd0, exp_out(ir_m, C_ALU)});
        #2 reset = 1'b1;
        #1;
        ir_m = 16'h0000;
        check("async_reset_outs", {11'd0, got_v}, {11'd0, exp_out(ir_m, C_WAIT)});
        check("async_reset_sx", {16'd0, sximm8}, 32'd0);
        @(posedge clk); #1;
        check("reset_edge_write", {31'd0, write}, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        run_instr(16'hD007, 1'b0);

        // Randomized instructions
        for (int i = 0; i < 60; i++) begin
            run_instr(rand_instr(), 1'($urandom_range(0, 1)));
        end
        s = 1'b0;
        @(posedge clk); #1;
        check("final_w", {31'd0, w}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_seq_ctrl.md
Name: regfile_seq_ctrl

Overview:
- Multi-cycle instruction sequencer for the 8x16 register-file datapath: register file, A/B/C pipeline registers, shifter, ALU and status register.
- Latches one 16-bit instruction on a start strobe, decodes it, and steps through a Moore FSM.
- Drives the datapath's read/write register numbers, write enable, load enables and mux selects each cycle, then returns to WAIT.
- Sits between the instruction source (test harness now, fetch unit later) and the datapath.

Parameters:
- WIDTH, 16, datapath/instruction width; sign-extension target for the immediate.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces WAIT and zeroes the instruction register.
- s  in  1  start strobe; sampled only in WAIT.
- in  in  WIDTH  instruction word; latched with s in WAIT.
- w  out  1  high only in WAIT (ready for next instruction).
- err  out  1  high for the DECODE cycle of an illegal instruction.
- readnum  out  3  register-file read address.
- writenum  out  3  register-file write address.
- write  out  1  register-file write enable.
- loada, loadb, loadc, loads  out  1 each  load enables for A, B, C and status.
- asel, bsel  out  1 each  asel=1 gives A operand 0; bsel=1 gives B operand sximm5 (always 0 here).
- vsel  out  2  writeback select: 0 = C, 2 = sximm8.
- shift  out  2  shifter op.
- ALUop  out  2  ALU op.
- sximm8  out  WIDTH  sign-extended IR[7:0].

Behaviour:
Instruction register (IR) and decode:
- IR loads `in` at a rising edge when state==WAIT and s==1. Otherwise IR holds.
- Fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- sximm8 = {{8{IR[7]}}, IR[7:0]}, purely combinational from IR.
- Legal encodings:
  - 110/10: MOV Rn,#imm8.
  - 110/00: MOV Rd,Rm{,sh}.
  - 101/00: ADD.
  - 101/01: CMP.
  - 101/10: AND.
  - 101/11: MVN.
- Anything else is illegal.

Outputs:
- Moore outputs, decoded from state and IR.
- Every output not listed for a state is 0.
- Reset value of all outputs is 0, except w=1.

States and outputs:
- WAIT: w=1. If s=1, go to DECODE; otherwise stay.
- DECODE: no datapath action. Next state:
  - illegal: err=1 this cycle, then WAIT.
  - MOV imm: WR_IMM.
  - MOV reg or MVN: GET_B.
  - ADD, CMP, AND: GET_A.
- GET_A: readnum=Rn, loada=1. Next GET_B.
- GET_B: readnum=Rm, loadb=1. Next ALU.
- ALU: shift=sh; ALUop = op for opcode 101, 00 for MOV reg. asel = 1 for MOV reg and MVN.
  - CMP: loads=1, loadc=0, then WAIT.
  - Other instructions: loadc=1, then WR_REG.
- WR_REG: write=1, writenum=Rd, vsel=0. Next WAIT.
- WR_IMM: write=1, writenum=Rn, vsel=2. Next WAIT.

Latency (non-WAIT cycles; w falls on the edge after s is sampled):
- MOV imm: 2.
- MOV reg: 4.
- MVN: 4.
- CMP: 4.
- ADD: 5.
- AND: 5.
- Illegal: 1.

Boundary conditions:
- s held high continuously: next instruction is accepted on the edge that leaves the final state into WAIT, plus one WAIT cycle. That is, `in` is sampled in the WAIT cycle, giving back-to-back operation with one WAIT cycle between instructions.
- s or `in` changes outside WAIT: ignored; IR is stable for the whole sequence.
- Rd==Rn==Rm: no special handling; the datapath registers provide the needed isolation.
- Reset asserted mid-sequence (any state): immediately, without waiting for clk:
  - state=WAIT, IR=0, write=0, w=1.
  - No partial write may occur after reset rises.
- Reset released: first instruction is accepted at the first edge with s=1.
- Exactly one register-file write per non-CMP legal instruction; zero writes for CMP and illegal instructions.

Test Plan:
- Reset, then s=1 for one cycle with in=16'hD007 (MOV R0,#7) -> w low for exactly 2 cycles; in WR_IMM: write=1, writenum=0, vsel=2, sximm8=16'h0007; w=1 afterwards.
- in=16'hD1FE (MOV R1,#-2) -> sximm8=16'hFFFE; write pulses once with writenum=1.
- in=16'hA140 (ADD R2,R1,R0) -> the following sequence, 5 cycles total, then w=1:
  - GET_A: readnum=1, loada=1.
  - GET_B: readnum=0, loadb=1.
  - ALU: loadc=1, ALUop=00, shift=00.
  - WR_REG: writenum=2, write=1, vsel=0.
- in=16'hA801 (CMP R0,R1) -> 4 non-WAIT cycles; loads=1 in ALU; write never asserted; loadc never asserted.
- in=16'h0000 -> err=1 for exactly one cycle; write=0 throughout; w returns high after 1 cycle.
- Start in=16'hA140; assert reset asynchronously (mid-clock) during the ALU state -> w=1 and write=0 before the next edge; no write occurs. After release, s with 16'hD007 executes normally.
